sync_packet_fifo: RTL and testbench

Single-clock packet FIFO built on inferred block RAM, with parametrised depth. It is the successor of the dual-clock packet FIFO for datapaths that share one clock.
- Store-and-forward only. Dirty and oversize packets are discarded on the write side by rolling back the write pointer, so the read side never sees them.
- Sits between a port's RX parser and the switch core input arbiter.

---
 rtl/sync_packet_fifo.sv | 269 ++++++++++++++++++++++++++
 tb/tb_sync_packet_fifo.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_packet_fifo
// Description : Single-clock store-and-forward packet FIFO on inferred block
//               RAM. Beats are written speculatively and only become visible
//               to the read side once the packet's last beat commits clean;
//               dirty packets, and packets that overflow the data store, are
//               discarded by rolling the speculative write pointer back to the
//               last commit point.
//
// Ports       : clk, reset_n            clock, async active-low reset
//               wr_data/wr_metadata     write beat, per-packet metadata
//               wr_last/wr_dirty/wr     last-beat flag, bad-packet flag, strobe
//               wr_full/wr_almost_full  write-side back-pressure
//               rd_data/rd_metadata     FWFT head beat and its packet metadata
//               rd_last/rd/rd_empty     head is last beat, pop, nothing ready
//               pkt_count/drop_count    committed / discarded packet counters
//               error                   one-cycle protocol-violation pulse
//
// Build option: SYNC_PACKET_FIFO_STATS_EN -- when defined, pkt_count and
//               drop_count are wrapping counters; otherwise both read as 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module sync_packet_fifo #(
    parameter int DATA_WIDTH         = 256,
    parameter int METADATA_WIDTH     = 32,
    parameter int DEPTH_LOG2         = 9,
    parameter int META_DEPTH_LOG2    = 7,
    parameter int ALMOST_FULL_OFFSET = 6,
    parameter int COUNTER_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic [METADATA_WIDTH-1:0] wr_metadata,
    input  logic                      wr_last,
    input  logic                      wr_dirty,
    input  logic                      wr,
    output logic                      wr_full,
    output logic                      wr_almost_full,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic [METADATA_WIDTH-1:0] rd_metadata,
    output logic                      rd_last,
    input  logic                      rd,
    output logic                      rd_empty,
    output logic [COUNTER_WIDTH-1:0]  pkt_count,
    output logic [COUNTER_WIDTH-1:0]  drop_count,
    output logic                      error
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                     c_DATA_DEPTH = 2 ** DEPTH_LOG2;
    localparam int                     c_META_DEPTH = 2 ** META_DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]      c_DPTR_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]      c_DATA_FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]      c_AF_OFFSET  = ALMOST_FULL_OFFSET[DEPTH_LOG2:0];
    localparam logic [META_DEPTH_LOG2:0] c_MPTR_ONE   = {{META_DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [META_DEPTH_LOG2:0] c_META_FULL  = {1'b1, {META_DEPTH_LOG2{1'b0}}};

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_IN_PKT  = 2'd1;
    localparam logic [1:0] c_ST_DISCARD = 2'd2;

    // ------------------------------------------------------------------------
    // Storage. The data RAM carries the last-beat flag alongside each beat.
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH:0]       r_data_mem [c_DATA_DEPTH];
    logic [METADATA_WIDTH-1:0] r_meta_mem [c_META_DEPTH];

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [1:0]                 r_state;
    logic [DEPTH_LOG2:0]        r_wr_ptr_spec;
    logic [DEPTH_LOG2:0]        r_wr_ptr_commit;
    logic [DEPTH_LOG2:0]        r_rd_ptr;
    logic [DEPTH_LOG2:0]        r_fetch_ptr;
    logic [META_DEPTH_LOG2:0]   r_meta_wr_ptr;
    logic [META_DEPTH_LOG2:0]   r_meta_rd_ptr;
    logic [DATA_WIDTH:0]        r_ram_q;
    logic                       r_ram_valid;
    logic [DATA_WIDTH:0]        r_out_q;
    logic                       r_out_valid;
    logic [METADATA_WIDTH-1:0]  r_rd_metadata;
    logic                       r_error;

    // ------------------------------------------------------------------------
    // Write-side decode
    // ------------------------------------------------------------------------
    logic [DEPTH_LOG2:0]      w_data_used;
    logic [DEPTH_LOG2:0]      w_data_free;
    logic [META_DEPTH_LOG2:0] w_meta_used;
    logic [META_DEPTH_LOG2:0] w_meta_free;
    logic                     w_full;
    logic                     w_can_write;
    logic                     w_accept;
    logic                     w_overflow;
    logic                     w_commit;
    logic                     w_discard_end;

    // Occupancy is measured against rd_ptr (not the fetch pointer) so that
    // beats sitting in the read pipeline are never overwritten.
    assign w_data_used   = r_wr_ptr_spec - r_rd_ptr;
    assign w_data_free   = c_DATA_FULL - w_data_used;
    assign w_meta_used   = r_meta_wr_ptr - r_meta_rd_ptr;
    assign w_meta_free   = c_META_FULL - w_meta_used;
    assign w_full        = (w_data_used == c_DATA_FULL) || (w_meta_used == c_META_FULL);

    assign w_can_write   = (r_state != c_ST_DISCARD);
    assign w_accept      = wr && w_can_write && !w_full;
    assign w_overflow    = wr && w_can_write && w_full;
    assign w_commit      = w_accept && wr_last && !wr_dirty;
    assign w_discard_end = wr && wr_last && (r_state == c_ST_DISCARD);

    assign wr_full        = w_full;
    assign wr_almost_full = (w_data_free <= c_AF_OFFSET) || (w_meta_free <= c_MPTR_ONE);

    // ------------------------------------------------------------------------
    // Write FSM and pointers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= c_ST_IDLE;
            r_wr_ptr_spec   <= '0;
            r_wr_ptr_commit <= '0;
            r_meta_wr_ptr   <= '0;
        end else begin
            if (w_accept) begin
                if (wr_last) begin
                    r_state <= c_ST_IDLE;
                    if (wr_dirty) begin
                        r_wr_ptr_spec <= r_wr_ptr_commit;
                    end else begin
                        r_wr_ptr_spec   <= r_wr_ptr_spec + c_DPTR_ONE;
                        r_wr_ptr_commit <= r_wr_ptr_spec + c_DPTR_ONE;
                        r_meta_wr_ptr   <= r_meta_wr_ptr + c_MPTR_ONE;
                    end
                end else begin
                    r_wr_ptr_spec <= r_wr_ptr_spec + c_DPTR_ONE;
                    r_state       <= c_ST_IN_PKT;
                end
            end else if (w_overflow) begin
                // The packet no longer fits: throw away what was written of it
                // and swallow the rest unless this beat already ends it.
                r_wr_ptr_spec <= r_wr_ptr_commit;
                r_state       <= wr_last ? c_ST_IDLE : c_ST_DISCARD;
            end else if (w_discard_end) begin
                r_state <= c_ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data_mem[r_wr_ptr_spec[DEPTH_LOG2-1:0]] <= {wr_last, wr_data};
        end
    end

    always_ff @(posedge clk) begin
        if (w_commit) begin
            r_meta_mem[r_meta_wr_ptr[META_DEPTH_LOG2-1:0]] <= wr_metadata;
        end
    end

    // ------------------------------------------------------------------------
    // Read side: RAM output register feeding a skid/output register. The fetch
    // pointer runs up to two beats ahead of rd_ptr and never past the commit
    // point, so speculative beats are invisible here.
    // ------------------------------------------------------------------------
    logic                     w_rd_empty;
    logic                     w_pop;
    logic                     w_pop_meta;
    logic                     w_out_load;
    logic                     w_ram_free;
    logic                     w_fetch;
    logic [META_DEPTH_LOG2:0] w_meta_rd_next;

    assign w_rd_empty     = !r_out_valid || (r_meta_wr_ptr == r_meta_rd_ptr);
    assign w_pop          = rd && !w_rd_empty;
    assign w_pop_meta     = w_pop && r_out_q[DATA_WIDTH];
    assign w_out_load     = !r_out_valid || w_pop;
    assign w_ram_free     = !r_ram_valid || w_out_load;
    assign w_fetch        = w_ram_free && (r_fetch_ptr != r_wr_ptr_commit);
    assign w_meta_rd_next = w_pop_meta ? (r_meta_rd_ptr + c_MPTR_ONE) : r_meta_rd_ptr;

    always_ff @(posedge clk) begin
        if (w_fetch) begin
            r_ram_q <= r_data_mem[r_fetch_ptr[DEPTH_LOG2-1:0]];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr      <= '0;
            r_fetch_ptr   <= '0;
            r_meta_rd_ptr <= '0;
            r_ram_valid   <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_q       <= '0;
            r_rd_metadata <= '0;
            r_error       <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_DPTR_ONE;
            end
            if (w_fetch) begin
                r_fetch_ptr <= r_fetch_ptr + c_DPTR_ONE;
            end
            if (w_ram_free) begin
                r_ram_valid <= w_fetch;
            end
            if (w_out_load) begin
                r_out_valid <= r_ram_valid;
                r_out_q     <= r_ram_q;
            end
            r_meta_rd_ptr <= w_meta_rd_next;
            // Re-read the head entry every cycle; a packet's data reaches the
            // output at least one cycle after its metadata was written.
            r_rd_metadata <= r_meta_mem[w_meta_rd_next[META_DEPTH_LOG2-1:0]];
            r_error       <= w_overflow || (rd && w_rd_empty);
        end
    end

    assign rd_data     = r_out_q[DATA_WIDTH-1:0];
    assign rd_last     = r_out_valid && r_out_q[DATA_WIDTH];
    assign rd_empty    = w_rd_empty;
    assign rd_metadata = r_rd_metadata;
    assign error       = r_error;

    // ------------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------------
`ifdef SYNC_PACKET_FIFO_STATS_EN
    localparam logic [COUNTER_WIDTH-1:0] c_CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

    logic                     w_drop;
    logic [COUNTER_WIDTH-1:0] r_pkt_count;
    logic [COUNTER_WIDTH-1:0] r_drop_count;

    assign w_drop = (w_accept && wr_last && wr_dirty) ||
                    (w_overflow && wr_last) ||
                    w_discard_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pkt_count  <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_commit) begin
                r_pkt_count <= r_pkt_count + c_CNT_ONE;
            end
            if (w_drop) begin
                r_drop_count <= r_drop_count + c_CNT_ONE;
            end
        end
    end

    assign pkt_count  = r_pkt_count;
    assign drop_count = r_drop_count;
`else
    assign pkt_count  = '0;
    assign drop_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_packet_fifo
// Description : Self-checking bench for sync_packet_fifo (16-deep data store,
//               8-deep metadata store). A cycle table covers a clean packet,
//               an empty read and a dirty packet; hand sequences cover
//               overflow/discard, streaming across the pointer wrap, and
//               reset in the middle of a packet and of a read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_packet_fifo;

    localparam int DW = 16;
    localparam int MW = 8;
    localparam int CW = 8;

`ifdef SYNC_PACKET_FIFO_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [DW-1:0] wr_data;
    logic [MW-1:0] wr_metadata;
    logic          wr_last;
    logic          wr_dirty;
    logic          wr;
    logic          wr_full;
    logic          wr_almost_full;
    logic [DW-1:0] rd_data;
    logic [MW-1:0] rd_metadata;
    logic          rd_last;
    logic          rd;
    logic          rd_empty;
    logic [CW-1:0] pkt_count;
    logic [CW-1:0] drop_count;
    logic          error;

    int n_pass  = 0;
    int n_total = 0;

    sync_packet_fifo #(
        .DATA_WIDTH         (DW),
        .METADATA_WIDTH     (MW),
        .DEPTH_LOG2         (4),
        .META_DEPTH_LOG2    (3),
        .ALMOST_FULL_OFFSET (6),
        .COUNTER_WIDTH      (CW)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .wr_data        (wr_data),
        .wr_metadata    (wr_metadata),
        .wr_last        (wr_last),
        .wr_dirty       (wr_dirty),
        .wr             (wr),
        .wr_full        (wr_full),
        .wr_almost_full (wr_almost_full),
        .rd_data        (rd_data),
        .rd_metadata    (rd_metadata),
        .rd_last        (rd_last),
        .rd             (rd),
        .rd_empty       (rd_empty),
        .pkt_count      (pkt_count),
        .drop_count     (drop_count),
        .error          (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [DW-1:0] wdata;
        logic          wlast;
        logic          wdirty;
        logic [MW-1:0] wmeta;
        logic          rd;
        logic          e_empty;
        logic [DW-1:0] e_data;
        logic          e_last;
        logic [MW-1:0] e_meta;
        logic          e_err;
    } vec_t;

    vec_t vecs [21];

    function automatic vec_t mk(input logic w, input logic [DW-1:0] d, input logic l,
                                input logic dt, input logic [MW-1:0] m, input logic r,
                                input logic ee, input logic [DW-1:0] ed, input logic el,
                                input logic [MW-1:0] em, input logic eerr);
        vec_t v;
        v.wr = w; v.wdata = d; v.wlast = l; v.wdirty = dt; v.wmeta = m; v.rd = r;
        v.e_empty = ee; v.e_data = ed; v.e_last = el; v.e_meta = em; v.e_err = eerr;
        return v;
    endfunction

    function automatic logic [31:0] cexp(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr = 1'b0; wr_data = '0; wr_last = 1'b0; wr_dirty = 1'b0; wr_metadata = '0; rd = 1'b0;
    endtask

    task automatic write_pkt(input int n, input logic [DW-1:0] base, input logic [MW-1:0] meta);
        for (int j = 0; j < n; j++) begin
            wr = 1'b1; wr_data = base + DW'(j); wr_last = (j == n - 1);
            wr_dirty = 1'b0; wr_metadata = meta;
            step();
        end
        idle_inputs();
    endtask

    task automatic read_pkt(input string tag, input int n, input logic [DW-1:0] base,
                            input logic [MW-1:0] meta);
        int budget = 0;
        while (rd_empty && budget < 20) begin
            step();
            budget++;
        end
        chk({tag, " ready"}, 32'(!rd_empty), 32'd1);
        for (int j = 0; j < n; j++) begin
            chk({tag, " data"}, 32'(rd_data), 32'(base + DW'(j)));
            chk({tag, " last"}, 32'(rd_last), 32'(j == n - 1));
            chk({tag, " meta"}, 32'(rd_metadata), 32'(meta));
            rd = 1'b1;
            step();
            rd = 1'b0;
        end
        chk({tag, " drained"}, 32'(rd_empty), 32'd1);
    endtask

    initial begin
        int got;
        int err_seen;
        int wi;
        int cyc;

        // Cycle table: inputs applied for one edge, outputs checked after it.
        //                wr  wdata     last dirty meta   rd   empty e_data   last e_meta err
        vecs[0]  = mk(1, 16'h0010, 0, 0, 8'h00, 0,  1, 16'h0000, 0, 8'h00, 0);
        vecs[1]  = mk(1, 16'h0011, 0, 0, 8'h00, 0,  1, 16'h0000, 0, 8'h00, 0);
        vecs[2]  = mk(1, 16'h0012, 0, 0, 8'h00, 0,  1, 16'h0000, 0, 8'h00, 0);
        vecs[3]  = mk(1, 16'h0013, 1, 0, 8'hA5, 0,  1, 16'h0000, 0, 8'h00, 0);
        vecs[4]  = mk(0, 16'h0000, 0, 0, 8'h00, 0,  1, 16'h0000, 0, 8'h00, 0);
        vecs[5]  = mk(0, 16'h0000, 0, 0, 8'h00, 0,  0, 16'h0010, 0, 8'hA5, 0);
        vecs[6]  = mk(0, 16'h0000, 0, 0, 8'h00, 1,  0, 16'h0011, 0, 8'hA5, 0);
        vecs[7]  = mk(0, 16'h0000, 0, 0, 8'h00, 1,  0, 16'h0012, 0, 8'hA5, 0);
        vecs[8]  = mk(0, 16'h0000, 0, 0, 8'h00, 1,  0, 16'h0013, 1, 8'hA5, 0);
        vecs[9]  = mk(0, 16'h0000, 0, 0, 8'h00, 1,  1, 16'h0000, 0, 8'h00, 0);
        vecs[10] = mk(0, 16'h0000, 0, 0, 8'h00, 1,  1, 16'h0000, 0, 8'h00, 1);
        vecs[11] = mk(0, 16'h0000, 0, 0, 8'h00, 0,  1, 16'h0000, 0, 8'h00, 0);
        vecs[12] = mk(1, 16'h0020, 0, 0, 8'h00, 0,  1, 16'h0000, 0, 8'h00, 0);
        vecs[13] = mk(1, 16'h0021, 0, 0, 8'h00, 0,  1, 16'h0000, 0, 8'h00, 0);
        vecs[14] = mk(1, 16'h0022, 1, 1, 8'hEE, 0,  1, 16'h0000, 0, 8'h00, 0);
        vecs[15] = mk(1, 16'h0030, 0, 0, 8'h00, 0,  1, 16'h0000, 0, 8'h00, 0);
        vecs[16] = mk(1, 16'h0031, 1, 0, 8'h5C, 0,  1, 16'h0000, 0, 8'h00, 0);
        vecs[17] = mk(0, 16'h0000, 0, 0, 8'h00, 0,  1, 16'h0000, 0, 8'h00, 0);
        vecs[18] = mk(0, 16'h0000, 0, 0, 8'h00, 0,  0, 16'h0030, 0, 8'h5C, 0);
        vecs[19] = mk(0, 16'h0000, 0, 0, 8'h00, 1,  0, 16'h0031, 1, 8'h5C, 0);
        vecs[20] = mk(0, 16'h0000, 0, 0, 8'h00, 1,  1, 16'h0000, 0, 8'h00, 0);

        // ---------------- reset state ----------------
        idle_inputs();
        reset_n = 1'b0;
        #2;
        chk("reset rd_empty", 32'(rd_empty), 32'd1);
        chk("reset wr_full", 32'(wr_full), 32'd0);
        chk("reset wr_almost_full", 32'(wr_almost_full), 32'd0);
        chk("reset rd_last", 32'(rd_last), 32'd0);
        chk("reset error", 32'(error), 32'd0);
        chk("reset rd_data", 32'(rd_data), 32'd0);
        chk("reset rd_metadata", 32'(rd_metadata), 32'd0);
        step();
        reset_n = 1'b1;
        step();

        // ---------------- table: clean 4-beat, empty read, dirty + clean ----
        for (int k = 0; k < 21; k++) begin
            wr = vecs[k].wr; wr_data = vecs[k].wdata; wr_last = vecs[k].wlast;
            wr_dirty = vecs[k].wdirty; wr_metadata = vecs[k].wmeta; rd = vecs[k].rd;
            step();
            chk($sformatf("vec%0d rd_empty", k), 32'(rd_empty), 32'(vecs[k].e_empty));
            chk($sformatf("vec%0d error", k), 32'(error), 32'(vecs[k].e_err));
            chk($sformatf("vec%0d rd_last", k), 32'(rd_last), 32'(vecs[k].e_last));
            if (!vecs[k].e_empty) begin
                chk($sformatf("vec%0d rd_data", k), 32'(rd_data), 32'(vecs[k].e_data));
                chk($sformatf("vec%0d rd_metadata", k), 32'(rd_metadata), 32'(vecs[k].e_meta));
            end
        end
        idle_inputs();
        chk("table pkt_count", 32'(pkt_count), cexp(2));
        chk("table drop_count", 32'(drop_count), cexp(1));

        // ---------------- oversize packet: 20 beats into 16 ----------------
        for (int i = 1; i <= 20; i++) begin
            wr = 1'b1; wr_data = 16'h0400 + DW'(i); wr_last = (i == 20);
            wr_dirty = 1'b0; wr_metadata = 8'h11;
            step();
            if (i == 9)  chk("ovf almost_full beat9", 32'(wr_almost_full), 32'd0);
            if (i == 10) chk("ovf almost_full beat10", 32'(wr_almost_full), 32'd1);
            if (i == 15) chk("ovf wr_full beat15", 32'(wr_full), 32'd0);
            if (i == 16) chk("ovf wr_full beat16", 32'(wr_full), 32'd1);
            if (i == 17) begin
                chk("ovf error pulse", 32'(error), 32'd1);
                chk("ovf rollback wr_full", 32'(wr_full), 32'd0);
                chk("ovf rollback almost_full", 32'(wr_almost_full), 32'd0);
            end
            if (i == 18) chk("ovf error single", 32'(error), 32'd0);
            if (i == 20) chk("ovf rd_empty", 32'(rd_empty), 32'd1);
        end
        idle_inputs();
        step();
        chk("ovf drop_count", 32'(drop_count), cexp(2));
        chk("ovf still empty", 32'(rd_empty), 32'd1);
        write_pkt(2, 16'h0500, 8'h77);
        read_pkt("post-ovf", 2, 16'h0500, 8'h77);

        // ---------------- streaming 16 x 2-beat packets across wrap --------
        got = 0; err_seen = 0; wi = 0; cyc = 0;
        while (got < 32 && cyc < 200) begin
            if (wi < 32) begin
                wr = 1'b1; wr_data = 16'h0600 + DW'(wi); wr_last = wi[0];
                wr_dirty = 1'b0; wr_metadata = 8'h80 + MW'(wi / 2);
                wi++;
            end else begin
                wr = 1'b0; wr_last = 1'b0;
            end
            rd = !rd_empty;
            if (rd) begin
                chk("stream data", 32'(rd_data), 32'(16'h0600 + DW'(got)));
                chk("stream last", 32'(rd_last), 32'(got % 2));
                chk("stream meta", 32'(rd_metadata), 32'(8'h80 + MW'(got / 2)));
                got++;
            end
            step();
            if (error) err_seen++;
            cyc++;
        end
        idle_inputs();
        chk("stream beats received", 32'(got), 32'd32);
        chk("stream error count", 32'(err_seen), 32'd0);
        chk("stream pkt_count", 32'(pkt_count), cexp(19));

        // ---------------- read while empty ----------------
        step();
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk("empty-rd error", 32'(error), 32'd1);
        chk("empty-rd rd_empty", 32'(rd_empty), 32'd1);
        step();
        chk("empty-rd error single", 32'(error), 32'd0);
        write_pkt(1, 16'h0700, 8'h99);
        read_pkt("single-beat", 1, 16'h0700, 8'h99);

        // ---------------- reset mid-read and mid-packet ----------------
        write_pkt(4, 16'h0800, 8'h42);
        cyc = 0;
        while (rd_empty && cyc < 20) begin
            step();
            cyc++;
        end
        chk("pre-reset ready", 32'(rd_empty), 32'd0);
        rd = 1'b1;
        step();
        rd = 1'b0;
        wr = 1'b1; wr_data = 16'h0850; wr_last = 1'b0;
        step();
        wr_data = 16'h0851;
        step();
        #3;
        reset_n = 1'b0;
        #1;
        chk("async reset rd_empty", 32'(rd_empty), 32'd1);
        chk("async reset rd_data", 32'(rd_data), 32'd0);
        chk("async reset rd_last", 32'(rd_last), 32'd0);
        chk("async reset rd_metadata", 32'(rd_metadata), 32'd0);
        chk("async reset wr_full", 32'(wr_full), 32'd0);
        chk("async reset error", 32'(error), 32'd0);
        chk("async reset pkt_count", 32'(pkt_count), 32'd0);
        chk("async reset drop_count", 32'(drop_count), 32'd0);
        idle_inputs();
        step();
        step();
        reset_n = 1'b1;
        step();
        write_pkt(3, 16'h0900, 8'h3C);
        read_pkt("post-reset", 3, 16'h0900, 8'h3C);
        chk("post-reset pkt_count", 32'(pkt_count), cexp(1));
        chk("post-reset drop_count", 32'(drop_count), cexp(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
